// File: rtl/spi_pkg.sv
// SPI master shared definitions
// Frame layout constants, FSM encoding, frame builder
package spi_pkg;

  localparam int FRAME_W = 24;
  localparam int INSTR_W = 16;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 13;

  localparam logic [1:0] W1W0     = 2'b00;
  localparam logic [4:0] LAST_BIT = 5'd24;
  localparam logic [4:0] RD_FIRST = 5'd16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCLK_HI,
    SCLK_LO,
    GAP
  } state_t;

  // instruction word followed by the data byte, zero for reads
  function automatic logic [FRAME_W-1:0] make_frame(
    input logic              rw,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] wdata
  );
    logic [INSTR_W-1:0] instr;
    instr = {rw, W1W0, addr};
    return {instr, rw ? {DATA_W{1'b0}} : wdata};
  endfunction

endpackage

// File: rtl/spi_if.sv
// SPI master request and pin bundle
// master modport faces the controller, slave modport the user
interface spi_if #(
  parameter int ADDR_SIZE = 13
);

  logic                 I_start;
  logic                 I_rw;
  logic [ADDR_SIZE-1:0] I_addr;
  logic [7:0]           I_wdata;
  logic                 I_sdi;
  logic                 O_sclk;
  logic                 _O_csb;
  logic                 O_sdo;
  logic                 O_busy;
  logic                 O_done;
  logic [7:0]           O_rdata;

  modport master (
    input  I_start, I_rw, I_addr, I_wdata, I_sdi,
    output O_sclk, _O_csb, O_sdo, O_busy, O_done, O_rdata
  );

  modport slave (
    output I_start, I_rw, I_addr, I_wdata, I_sdi,
    input  O_sclk, _O_csb, O_sdo, O_busy, O_done, O_rdata
  );

endinterface

// File: rtl/spi_sclk_div.sv
// SCLK half-period divider
// tick marks the last clk cycle of each half period
module spi_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // restart at each tick so every state gets a full half period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (!en || tick)
      cnt <= '0;
    else
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/spi_master.sv
// SPI master for 24-bit single-byte register frames
// mode 0 timing: sdo moves on falling SCLK, sdi taken late in high phase
module spi_master
  import spi_pkg::*;
#(
  parameter int ADDR_SIZE = 13,
  parameter int CLK_DIV   = 4
) (
  input logic   I_clk,
  input logic   _I_rstb,
  spi_if.master bus
);

  state_t state, nxt;

  logic                 tick;
  logic                 capture;
  logic                 active;
  logic                 rw_q;
  logic                 done_q;
  logic [4:0]           bitcnt;
  logic [FRAME_W-1:0]   sr;
  logic [DATA_W-1:0]    rx;
  logic [DATA_W-1:0]    rdata;
  logic [ADDR_SIZE-1:0] addr_in;
  logic [ADDR_W-1:0]    addr_ext;

  assign addr_in  = bus.I_addr;
  assign addr_ext = ADDR_W'(addr_in);

  spi_sclk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk   (I_clk),
    .rst_n (_I_rstb),
    .en    (state != IDLE),
    .tick  (tick)
  );

  // state register
  always_ff @(posedge I_clk or negedge _I_rstb) begin
    if (!_I_rstb)
      state <= IDLE;
    else
      state <= nxt;
  end

  // next state; start is only looked at in IDLE
  always_comb begin
    nxt     = state;
    capture = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.I_start) begin
          nxt     = SETUP;
          capture = 1'b1;
        end
      end
      SETUP:   if (tick) nxt = SCLK_HI;
      SCLK_HI: if (tick) nxt = SCLK_LO;
      SCLK_LO: begin
        if (tick)
          nxt = (bitcnt == LAST_BIT) ? GAP : SCLK_HI;
      end
      GAP:     if (tick) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // frame shift, read capture and completion pulse
  always_ff @(posedge I_clk or negedge _I_rstb) begin
    if (!_I_rstb) begin
      sr     <= '0;
      rx     <= '0;
      rdata  <= '0;
      rw_q   <= 1'b0;
      bitcnt <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (capture) begin
        sr     <= make_frame(bus.I_rw, addr_ext, bus.I_wdata);
        rw_q   <= bus.I_rw;
        bitcnt <= '0;
        rx     <= '0;
      end else if (state == SCLK_HI && tick) begin
        sr     <= {sr[FRAME_W-2:0], 1'b0};
        bitcnt <= bitcnt + 5'd1;
        if (bitcnt >= RD_FIRST)
          rx <= {rx[DATA_W-2:0], bus.I_sdi};
      end else if (state == SCLK_LO && tick && bitcnt == LAST_BIT) begin
        done_q <= 1'b1;
        if (rw_q)
          rdata <= rx;
      end
    end
  end

  assign active      = (state == SETUP) || (state == SCLK_HI) ||
                       (state == SCLK_LO);
  assign bus._O_csb  = !active;
  assign bus.O_sclk  = (state == SCLK_HI);
  assign bus.O_sdo   = active ? sr[FRAME_W-1] : 1'b0;
  assign bus.O_busy  = (state != IDLE);
  assign bus.O_done  = done_q;
  assign bus.O_rdata = rdata;

endmodule

// File: tb/tb_spi_master.sv
// Testbench for spi_master
// Cycle model of frame timing plus directed register accesses
module tb_spi_master;

  localparam int D  = 4;
  localparam int D1 = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   chk_on = 1'b0;

  always #5 clk = ~clk;

  spi_if #(.ADDR_SIZE(13)) b0 ();
  spi_if #(.ADDR_SIZE(5))  b1 ();

  spi_master #(.ADDR_SIZE(13), .CLK_DIV(D)) dut0 (
    .I_clk   (clk),
    ._I_rstb (rst_n),
    .bus     (b0)
  );

  spi_master #(.ADDR_SIZE(5), .CLK_DIV(D1)) dut1 (
    .I_clk   (clk),
    ._I_rstb (rst_n),
    .bus     (b1)
  );

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  // slave: byte goes out MSB first on the last 8 pulses
  logic [7:0] sbyte = 8'h3C;
  int sc = 0;
  always @(negedge b0.O_sclk or posedge b0._O_csb)
    if (b0._O_csb) sc <= 0;
    else sc <= sc + 1;
  assign b0.I_sdi = (!b0._O_csb && sc >= 16 && sc < 24) ?
                    sbyte[23-sc] : 1'b0;
  assign b1.I_sdi = 1'b0;

  // model: n = cycles since busy rose, -1 when idle
  int n = -1;
  logic [23:0] mf = '0;
  logic mrw = 1'b0;
  logic [7:0] mrd = 8'h00;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      n   <= -1;
      mrd <= 8'h00;
    end else if (n >= 0) begin
      n <= (n == 50*D-1) ? -1 : n + 1;
      if (n == 49*D-1 && mrw) mrd <= sbyte;
    end else if (b0.I_start) begin
      n   <= 0;
      mrw <= b0.I_rw;
      mf  <= {b0.I_rw, 2'b00, b0.I_addr,
              b0.I_rw ? 8'h00 : b0.I_wdata};
    end

  // {csb, sclk, busy, done} from position in the frame
  function automatic logic [3:0] exp_ctl(int t);
    int m;
    if (t < 0) return 4'b1000;
    if (t < D) return 4'b0010;
    if (t < 49*D) begin
      m = (t - D) % (2*D);
      return {1'b0, m < D, 1'b1, 1'b0};
    end
    return {1'b1, 1'b0, 1'b1, t == 49*D};
  endfunction

  // {defined, value} of sdo
  function automatic logic [1:0] exp_sdo(int t, logic [23:0] f);
    int m;
    int k;
    if (t < 0) return 2'b10;
    if (t < D) return {1'b1, f[23]};
    if (t >= 49*D) return 2'b00;
    m = t - D;
    k = m / (2*D);
    if ((m % (2*D)) < D) return {1'b1, f[23-k]};
    if (k < 23) return {1'b1, f[22-k]};
    return 2'b00;
  endfunction

  function automatic void chk_sdo(logic [1:0] e, logic a);
    if (e[1]) chk("sdo", a, e[0]);
  endfunction

  // per-cycle compare of dut0 against the model
  always @(negedge clk)
    if (chk_on) begin
      chk("cycle", {b0._O_csb, b0.O_sclk, b0.O_busy, b0.O_done,
                    b0.O_rdata}, {exp_ctl(n), mrd});
      chk_sdo(exp_sdo(n, mf), b0.O_sdo);
    end

  // frame monitors
  logic [23:0] cap = '0;
  logic [23:0] cap1 = '0;
  logic psclk = 1'b0;
  logic psclk1 = 1'b0;
  logic pcsb = 1'b1;
  logic [7:0] rd_done = '0;
  int pulses = 0;
  int pulses1 = 0;
  int csb_lo = 0;
  int bz = 0;
  int bz1 = 0;
  int dones = 0;
  int hirun = 0;
  int lasthi = 0;
  always @(negedge clk) begin
    psclk  <= b0.O_sclk;
    psclk1 <= b1.O_sclk;
    pcsb   <= b0._O_csb;
    if (b0.O_sclk && !psclk) begin
      cap    <= {cap[22:0], b0.O_sdo};
      pulses <= pulses + 1;
    end
    if (b1.O_sclk && !psclk1) begin
      cap1    <= {cap1[22:0], b1.O_sdo};
      pulses1 <= pulses1 + 1;
    end
    if (!b0._O_csb) csb_lo <= csb_lo + 1;
    if (b0.O_busy) bz <= bz + 1;
    if (b1.O_busy) bz1 <= bz1 + 1;
    if (b0.O_done) begin
      dones   <= dones + 1;
      rd_done <= b0.O_rdata;
    end
    if (b0._O_csb) hirun <= hirun + 1;
    else begin
      if (pcsb) lasthi <= hirun;
      hirun <= 0;
    end
  end

  task automatic start0(logic rw, logic [12:0] a, logic [7:0] wd);
    @(negedge clk);
    b0.I_start = 1'b1;
    b0.I_rw    = rw;
    b0.I_addr  = a;
    b0.I_wdata = wd;
    @(negedge clk);
    b0.I_start = 1'b0;
  endtask

  task automatic idle0();
    int c = 0;
    while (b0.O_busy && c < 1000) begin
      @(negedge clk);
      c++;
    end
    chk("idle0_wait", c < 1000, 1);
    @(negedge clk);
  endtask

  task automatic wait_pulses(int target);
    int c = 0;
    while (pulses < target && c < 1000) begin
      @(negedge clk);
      c++;
    end
    chk("pulse_wait", c < 1000, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, c0, d0, z0, c;
    b0.I_start = 0; b0.I_rw = 0; b0.I_addr = '0; b0.I_wdata = '0;
    b1.I_start = 0; b1.I_rw = 0; b1.I_addr = '0; b1.I_wdata = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst0", {b0._O_csb, b0.O_sclk, b0.O_sdo, b0.O_busy,
                 b0.O_done, b0.O_rdata}, 13'h1000);
    chk("rst1", {b1._O_csb, b1.O_sclk, b1.O_sdo, b1.O_busy,
                 b1.O_done, b1.O_rdata}, 13'h1000);
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // write 0x0014 <- A5
    p0 = pulses; c0 = csb_lo; d0 = dones; z0 = bz;
    start0(0, 13'h0014, 8'hA5);
    idle0();
    chk("wr_pulses", pulses - p0, 24);
    chk("wr_frame", cap, 24'h0014A5);
    chk("wr_csb_low", csb_lo - c0, 49*D);
    chk("wr_busy", bz - z0, 50*D);
    chk("wr_dones", dones - d0, 1);
    chk("wr_rdata", b0.O_rdata, 8'h00);

    // read 0x0001, slave returns 3C
    start0(1, 13'h0001, 8'hFF);
    idle0();
    chk("rd_instr", cap[23:8], 16'h8001);
    chk("rd_frame", cap, 24'h800100);
    chk("rd_at_done", rd_done, 8'h3C);

    // write leaves rdata alone
    start0(0, 13'h0ABC, 8'h5A);
    idle0();
    chk("wr2_frame", cap, 24'h0ABC5A);
    chk("wr2_rdata", b0.O_rdata, 8'h3C);

    // back-to-back with start held
    p0 = pulses; d0 = dones;
    @(negedge clk);
    b0.I_start = 1; b0.I_rw = 0;
    b0.I_addr = 13'h0002; b0.I_wdata = 8'h11;
    c = 0;
    while (dones < d0 + 2 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    b0.I_start = 0;
    chk("b2b_wait", c < 1000, 1);
    idle0();
    repeat (3*D) @(negedge clk);
    chk("b2b_dones", dones - d0, 2);
    chk("b2b_pulses", pulses - p0, 48);
    chk("b2b_gap", lasthi >= D, 1);
    chk("b2b_frame", cap, 24'h000211);

    // start pulse mid-frame is dropped
    p0 = pulses; d0 = dones;
    start0(0, 13'h0003, 8'h77);
    wait_pulses(p0 + 10);
    b0.I_start = 1; b0.I_rw = 1;
    b0.I_addr = 13'h1FFF; b0.I_wdata = 8'h00;
    @(negedge clk);
    b0.I_start = 0;
    idle0();
    repeat (3*D) @(negedge clk);
    chk("ign_frame", cap, 24'h000377);
    chk("ign_dones", dones - d0, 1);
    chk("ign_busy", b0.O_busy, 0);

    // reset in the middle of a read
    sbyte = 8'hC3;
    p0 = pulses; d0 = dones;
    start0(1, 13'h0005, 8'h00);
    wait_pulses(p0 + 12);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort", {b0._O_csb, b0.O_sclk, b0.O_busy, b0.O_done,
                  b0.O_rdata}, 12'h800);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4*D) @(negedge clk);
    chk("abort_dones", dones - d0, 0);
    p0 = pulses;
    start0(0, 13'h1FFF, 8'h0F);
    idle0();
    chk("post_frame", cap, 24'h1FFF0F);
    chk("post_pulses", pulses - p0, 24);
    chk("post_dones", dones - d0, 1);

    // narrow address, fast divider
    z0 = bz1; p0 = pulses1;
    @(negedge clk);
    b1.I_start = 1; b1.I_rw = 0;
    b1.I_addr = 5'h1F; b1.I_wdata = 8'h81;
    @(negedge clk);
    b1.I_start = 0;
    c = 0;
    while (b1.O_busy && c < 1000) begin
      @(negedge clk);
      c++;
    end
    chk("p5_wait", c < 1000, 1);
    @(negedge clk);
    chk("p5_busy", bz1 - z0, 100);
    chk("p5_frame", cap1, 24'h001F81);
    chk("p5_pulses", pulses1 - p0, 24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter ADDR_SIZE, default 13, SHALL set the address width (legal 1..13); the address is zero-extended to 13 bits on the wire.
REQ-002 Parameter CLK_DIV, default 4, SHALL set I_clk cycles per SCLK half-period (legal >= 2).
REQ-003 I_clk  input  1  system clock; all logic SHALL use its rising edge only.
REQ-004 _I_rstb  input  1  asynchronous, active-low reset.
REQ-005 I_start  input  1  transfer request, sampled only in IDLE.
REQ-006 I_rw  input  1  1 = read, 0 = write; captured with I_start.
REQ-007 I_addr  input  ADDR_SIZE  register address; captured with I_start.
REQ-008 I_wdata  input  8  write byte; captured with I_start.
REQ-009 I_sdi  input  1  serial data from the slave SDO.
REQ-010 O_sclk  output  1  serial clock to the slave; idles low.
REQ-011 _O_csb  output  1  active-low chip select to the slave.
REQ-012 O_sdo  output  1  serial data to the slave SDI.
REQ-013 O_busy  output  1  high while a transfer is in progress.
REQ-014 O_done  output  1  one-cycle completion pulse.
REQ-015 O_rdata  output  8  last byte read from the slave.

Function
REQ-016 The frame SHALL be 24 bits, MSB first: bit23 = R/W, bits22:21 = W1:W0 = 00 (single byte), bits20:8 = address, bits7:0 = write data (don't-care/0 for reads).
REQ-017 FSM states SHALL be IDLE, SETUP, SCLK_HI, SCLK_LO and GAP.
REQ-018 IDLE: _O_csb=1, O_sclk=0, O_sdo=0, O_busy=0; I_start=1 SHALL capture the inputs, assert O_busy on the next cycle and enter SETUP.
REQ-019 SETUP: _O_csb=0, O_sdo=bit23, O_sclk=0, held for CLK_DIV cycles, then SCLK_HI.
REQ-020 SCLK_HI: O_sclk=1 for CLK_DIV cycles; then SCLK_LO.
REQ-021 SCLK_LO: O_sclk=0 for CLK_DIV cycles; O_sdo SHALL change to the next bit on the first cycle of SCLK_LO (falling edge), giving CLK_DIV cycles of setup before the next rising edge.
REQ-022 After the 24th SCLK_LO, the FSM SHALL enter GAP; _O_csb SHALL rise on GAP entry, O_done SHALL pulse that same cycle, and GAP SHALL last CLK_DIV cycles before IDLE.
REQ-023 Total O_busy duration SHALL be exactly 50*CLK_DIV cycles (200 at default).
REQ-024 For reads, I_sdi SHALL be sampled on the last I_clk cycle of each SCLK_HI for bits 7:0, shifted in MSB first; O_rdata SHALL update on the O_done cycle.
REQ-025 Write transfers SHALL leave O_rdata unchanged.
REQ-026 I_start while O_busy=1 SHALL be ignored (no queuing); I_start asserted in the same cycle as the GAP->IDLE transition SHALL be ignored; I_start on the first IDLE cycle SHALL be accepted.
REQ-027 Captured I_rw/I_addr/I_wdata SHALL be unaffected by input changes during a transfer.
REQ-028 A 5-bit bit counter and a divider counter of ceil(log2(CLK_DIV)) bits SHALL be used; no counter SHALL wrap inside a frame.

Reset
REQ-029 On _I_rstb=0, asynchronously: state=IDLE, _O_csb=1, O_sclk=0, O_sdo=0, O_busy=0, O_done=0, O_rdata=8'h00, all counters and shift registers 0.
REQ-030 Reset mid-transfer SHALL abort the frame without an O_done pulse; the first I_start after release SHALL start a clean frame.

Structure
REQ-031 Package spi_pkg SHALL hold frame width (24), instruction width (16), data width (8), W1W0 code (2'b00) and the FSM state encoding.
REQ-032 One sub-module, spi_sclk_div, SHALL generate the half-period tick from CLK_DIV; the FSM, shift registers and bit counter remain in spi_master.

Verification
REQ-033 Write: I_rw=0, I_addr=13'h0014, I_wdata=8'hA5 -> 24 SCLK pulses, bits sampled at rising edges = 24'h0014A5, _O_csb low for 49*CLK_DIV cycles, O_done once.
REQ-034 Read: I_rw=1, I_addr=13'h0001, slave model returning 8'h3C -> instruction 16'h8001 observed, O_rdata=8'h3C on the O_done cycle.
REQ-035 Back-to-back: I_start held high continuously -> second frame begins the cycle after GAP ends, with _O_csb high for >= CLK_DIV cycles between frames.
REQ-036 Busy-ignore: pulse I_start with I_addr=13'h1FFF at bit 10 of a frame -> the current frame is unchanged and no second frame follows.
REQ-037 Reset abort: assert _I_rstb=0 at bit 12 -> _O_csb=1 and O_sclk=0 immediately, no O_done, O_rdata=8'h00.
REQ-038 Parameters ADDR_SIZE=5, CLK_DIV=2: I_addr=5'h1F -> address field 13'h001F, O_busy high for exactly 100 cycles.
